// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file writeback path.
//   XLEN  - data width
//   NREGS - architectural register count
//   AW    - register address width
//   wb_req_t   - one writeback request (destination address + data)
//   reg_decode - one-hot decode of a register address; r0 never decodes
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // r0 is hardwired zero, so it is never reported as pending.
  function automatic logic [NREGS-1:0] reg_decode(input logic [AW-1:0] a);
    logic [NREGS-1:0] onehot;
    onehot    = '0;
    onehot[a] = 1'b1;
    onehot[0] = 1'b0;
    return onehot;
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// wb_hold_slot: one-entry holding register for a writeback requester.
//   clk, reset (sync, active-low)
//   valid, req_in   - incoming request
//   ready           - slot can accept this cycle (empty, or being drained now)
//   grant           - arbiter drains the slot at the next edge
//   full, req_out   - slot occupancy and held request
// Requests to r0 complete the handshake but are dropped without loading.
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    valid,
  input  wb_req_t req_in,
  input  logic    grant,
  output logic    ready,
  output logic    full,
  output wb_req_t req_out
);

  logic    full_q, full_d;
  wb_req_t req_q, req_d;
  logic    accept;

  always_comb begin
    ready  = ~full_q | grant;
    accept = valid & ready;
    full_d = full_q;
    req_d  = req_q;
    if (grant) full_d = 1'b0;
    // A new accept on the drain edge refills the slot immediately.
    if (accept && (req_in.addr != '0)) begin
      full_d = 1'b1;
      req_d  = req_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  assign full    = full_q;
  assign req_out = req_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between two
// writeback requesters (port 0: ALU, port 1: load/multi-cycle unit).
//   clk, reset (sync, active-low)
//   wbN_valid/addr/data/ready - requester handshakes into one-entry slots
//   we3/a3/wd3                - registered register-file write port
//   pend_mask                 - registers with a write held or being issued
// Optional feature macro WB_BYPASS_EN adds a1/a2/rd1_rf/rd2_rf/rd1/rd2 and
// forwards the write being issued to the read ports in the cycle before the
// register file commits it.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wb0_valid,
  input  logic [AW-1:0]    wb0_addr,
  input  logic [XLEN-1:0]  wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [AW-1:0]    wb1_addr,
  input  logic [XLEN-1:0]  wb1_data,
  output logic             wb1_ready,
  output logic             we3,
  output logic [AW-1:0]    a3,
  output logic [XLEN-1:0]  wd3,
  output logic [NREGS-1:0] pend_mask
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  input  logic [XLEN-1:0]  rd1_rf,
  input  logic [XLEN-1:0]  rd2_rf,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2
`endif
);

  wb_req_t wb0_req, wb1_req;
  wb_req_t slot0, slot1;
  logic    full0, full1;
  logic    grant0, grant1;

  logic            we3_q, we3_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  // last_q = index of the port granted most recently; 1 at reset so port 0
  // wins the first tie.
  logic            last_q, last_d;

  always_comb begin
    wb0_req.addr = wb0_addr;
    wb0_req.data = wb0_data;
    wb1_req.addr = wb1_addr;
    wb1_req.data = wb1_data;
  end

  wb_hold_slot u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .valid   (wb0_valid),
    .req_in  (wb0_req),
    .grant   (grant0),
    .ready   (wb0_ready),
    .full    (full0),
    .req_out (slot0)
  );

  wb_hold_slot u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .valid   (wb1_valid),
    .req_in  (wb1_req),
    .grant   (grant1),
    .ready   (wb1_ready),
    .full    (full1),
    .req_out (slot1)
  );

  // Grant depends only on slot flags and last_q, keeping ready free of valid.
  always_comb begin
    grant0 = full0 & (~full1 | last_q);
    grant1 = full1 & (~full0 | ~last_q);
    we3_d  = 1'b0;
    a3_d   = a3_q;
    wd3_d  = wd3_q;
    last_d = last_q;
    if (grant0) begin
      we3_d  = 1'b1;
      a3_d   = slot0.addr;
      wd3_d  = slot0.data;
      last_d = 1'b0;
    end else if (grant1) begin
      we3_d  = 1'b1;
      a3_d   = slot1.addr;
      wd3_d  = slot1.data;
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      last_q <= 1'b1;
    end else begin
      we3_q  <= we3_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      last_q <= last_d;
    end
  end

  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

  always_comb begin
    pend_mask = '0;
    if (full0) pend_mask = pend_mask | reg_decode(slot0.addr);
    if (full1) pend_mask = pend_mask | reg_decode(slot1.addr);
    if (we3_q) pend_mask = pend_mask | reg_decode(a3_q);
  end

`ifdef WB_BYPASS_EN
  assign rd1 = (we3_q && (a3_q == a1) && (a1 != '0)) ? wd3_q : rd1_rf;
  assign rd2 = (we3_q && (a3_q == a2) && (a2 != '0)) ? wd3_q : rd2_rf;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic             clk;
  logic             reset;
  logic             wb0_valid, wb1_valid;
  logic [AW-1:0]    wb0_addr, wb1_addr;
  logic [XLEN-1:0]  wb0_data, wb1_data;
  logic             wb0_ready, wb1_ready;
  logic             we3;
  logic [AW-1:0]    a3;
  logic [XLEN-1:0]  wd3;
  logic [NREGS-1:0] pend_mask;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]    a1, a2;
  logic [XLEN-1:0]  rd1_rf, rd2_rf, rd1, rd2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .wb0_valid (wb0_valid),
    .wb0_addr  (wb0_addr),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_addr  (wb1_addr),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .pend_mask (pend_mask)
`ifdef WB_BYPASS_EN
    ,
    .a1        (a1),
    .a2        (a2),
    .rd1_rf    (rd1_rf),
    .rd2_rf    (rd2_rf),
    .rd1       (rd1),
    .rd2       (rd2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [4:0] ad0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] ad1, input logic [31:0] d1);
    wb0_valid = v0; wb0_addr = ad0; wb0_data = d0;
    wb1_valid = v1; wb1_addr = ad1; wb1_data = d1;
  endtask

  // ---------------- reference model: two depth-1 queues + round robin -------
  wb_req_t m_q0[$];
  wb_req_t m_q1[$];
  int      m_last;
  logic    m_we;
  wb_req_t m_out;

  function automatic int m_pick();
    if (m_q0.size() != 0 && m_q1.size() != 0) return (m_last == 1) ? 0 : 1;
    if (m_q0.size() != 0) return 0;
    if (m_q1.size() != 0) return 1;
    return -1;
  endfunction

  function automatic logic m_ready(input int port);
    int g = m_pick();
    if (port == 0) return (m_q0.size() == 0) || (g == 0);
    return (m_q1.size() == 0) || (g == 1);
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (m_q0[i]) p[m_q0[i].addr] = 1'b1;
    foreach (m_q1[i]) p[m_q1[i].addr] = 1'b1;
    if (m_we) p[m_out.addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic m_reset();
    m_q0.delete(); m_q1.delete();
    m_last = 1; m_we = 1'b0; m_out = '0;
  endtask

  task automatic m_step(input logic rst_n,
                        input logic v0, input logic [4:0] ad0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] ad1, input logic [31:0] d1);
    int g;
    logic acc0, acc1;
    wb_req_t e;
    if (!rst_n) begin
      m_reset();
      return;
    end
    g    = m_pick();
    acc0 = v0 && m_ready(0);
    acc1 = v1 && m_ready(1);
    m_we = (g >= 0);
    if (g == 0) m_out = m_q0.pop_front();
    else if (g == 1) m_out = m_q1.pop_front();
    if (g >= 0) m_last = g;
    if (acc0 && ad0 != 0) begin e.addr = ad0; e.data = d0; m_q0.push_back(e); end
    if (acc1 && ad1 != 0) begin e.addr = ad1; e.data = d1; m_q1.push_back(e); end
  endtask

  // ---------------- directed vector table --------------------------------
  typedef struct {
    logic        rst_n;
    logic        v0;  logic [4:0] ad0; logic [31:0] d0;
    logic        v1;  logic [4:0] ad1; logic [31:0] d1;
    logic        ew;  logic [4:0] ea;  logic [31:0] ed;
    logic [31:0] ep;
    logic        er0; logic er1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // port 0 alone, addr 5
    tbl[0] = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 0,            32'h20, 1, 1};
    tbl[1] = '{1, 0, 0, 0,            0, 0, 0,      1, 5, 32'hDEADBEEF, 32'h20, 1, 1};
    tbl[2] = '{1, 0, 0, 0,            0, 0, 0,      0, 5, 32'hDEADBEEF, 32'h00, 1, 1};
    // port 1 to r0: accepted, dropped
    tbl[3] = '{1, 0, 0, 0,            1, 0, 32'h123, 0, 5, 32'hDEADBEEF, 32'h00, 1, 1};
    tbl[4] = '{1, 0, 0, 0,            0, 0, 0,      0, 5, 32'hDEADBEEF, 32'h00, 1, 1};
    // reset, then both ports to r7 on the same edge
    tbl[5] = '{0, 0, 0, 0,            0, 0, 0,      0, 0, 0,            32'h00, 1, 1};
    tbl[6] = '{1, 1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 0,            32'h80, 1, 0};
    tbl[7] = '{1, 0, 0, 0,            0, 0, 0,      1, 7, 32'h11,       32'h80, 1, 1};
    tbl[8] = '{1, 0, 0, 0,            0, 0, 0,      1, 7, 32'h22,       32'h80, 1, 1};
    tbl[9] = '{1, 0, 0, 0,            0, 0, 0,      0, 7, 32'h22,       32'h00, 1, 1};
  end

  initial begin
    logic [4:0] exp_a;
    logic       rst_n_r, v0, v1;
    logic [4:0] ad0, ad1;
    logic [31:0] d0, d1;

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
    a1 = '0; a2 = '0; rd1_rf = '0; rd2_rf = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    chk("reset_we3", {31'b0, we3}, 32'd0);
    chk("reset_a3", {27'b0, a3}, 32'd0);
    chk("reset_wd3", wd3, 32'd0);
    chk("reset_pend", pend_mask, 32'd0);
    chk("reset_rdy0", {31'b0, wb0_ready}, 32'd1);
    chk("reset_rdy1", {31'b0, wb1_ready}, 32'd1);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst_n;
      drive(tbl[i].v0, tbl[i].ad0, tbl[i].d0, tbl[i].v1, tbl[i].ad1, tbl[i].d1);
      step();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("vec%0d_we3", i), {31'b0, we3}, {31'b0, tbl[i].ew});
      chk($sformatf("vec%0d_a3", i), {27'b0, a3}, {27'b0, tbl[i].ea});
      chk($sformatf("vec%0d_wd3", i), wd3, tbl[i].ed);
      chk($sformatf("vec%0d_pend", i), pend_mask, tbl[i].ep);
      chk($sformatf("vec%0d_rdy0", i), {31'b0, wb0_ready}, {31'b0, tbl[i].er0});
      chk($sformatf("vec%0d_rdy1", i), {31'b0, wb1_ready}, {31'b0, tbl[i].er1});
    end

    // continuous contention from reset: 1,2,1,2... every cycle
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(1, 1, 32'hA1, 1, 2, 32'hB2);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) begin
        chk("cont_first_we3", {31'b0, we3}, 32'd0);
      end else begin
        exp_a = (k % 2 == 1) ? 5'd1 : 5'd2;
        chk($sformatf("cont%0d_we3", k), {31'b0, we3}, 32'd1);
        chk($sformatf("cont%0d_a3", k), {27'b0, a3}, {27'b0, exp_a});
      end
    end

    // reset mid-operation with both slots full
    chk("pre_rst_pend", pend_mask, 32'h6);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk("midrst_we3", {31'b0, we3}, 32'd0);
    chk("midrst_pend", pend_mask, 32'd0);
    reset = 1'b1;
    chk("midrst_rdy0", {31'b0, wb0_ready}, 32'd1);
    chk("midrst_rdy1", {31'b0, wb1_ready}, 32'd1);
    step();
    chk("postrst_we3", {31'b0, we3}, 32'd0);

`ifdef WB_BYPASS_EN
    drive(1, 9, 32'h55, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    a1 = 5'd9; rd1_rf = 32'h0; a2 = 5'd3; rd2_rf = 32'h77;
    #1;
    chk("byp_rd1_hit", rd1, 32'h55);
    chk("byp_rd2_miss", rd2, 32'h77);
    a1 = 5'd0; rd1_rf = 32'hAB; a2 = 5'd9; rd2_rf = 32'h0;
    #1;
    chk("byp_rd1_r0", rd1, 32'hAB);
    chk("byp_rd2_hit", rd2, 32'h55);
    step();
    a1 = 5'd9; rd1_rf = 32'hCC;
    #1;
    chk("byp_rd1_idle", rd1, 32'hCC);
`endif

    // randomized run against the queue model
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    m_reset();
    for (int c = 0; c < 400; c++) begin
      chk("rnd_we3", {31'b0, we3}, {31'b0, m_we});
      chk("rnd_a3", {27'b0, a3}, {27'b0, m_out.addr});
      chk("rnd_wd3", wd3, m_out.data);
      chk("rnd_pend", pend_mask, m_pend());
      chk("rnd_rdy0", {31'b0, wb0_ready}, {31'b0, m_ready(0)});
      chk("rnd_rdy1", {31'b0, wb1_ready}, {31'b0, m_ready(1)});
      rst_n_r = ($urandom_range(0, 39) != 0);
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      ad0 = 5'($urandom_range(0, 7));
      ad1 = 5'($urandom_range(0, 7));
      d0  = $urandom;
      d1  = $urandom;
      reset = rst_n_r;
      drive(v0, ad0, d0, v1, ad1, d1);
      m_step(rst_n_r, v0, ad0, d0, v1, ad1, d1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
